// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates the common data bus between the ALU and the load/store buffer.
// Each producer fills a small private FIFO. A round-robin grant pops one head entry
// per cycle into a registered broadcast that all CDB snoopers observe.
// A reorder-buffer flush empties both FIFOs and kills the broadcast in flight.
module cdb_arbiter #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    alu_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_dest,
  input  logic [DATA_WIDTH-1:0]   alu_value,
  input  logic [DATA_WIDTH-1:0]   alu_next_pc,
  output logic                    alu_ready,
  input  logic                    lsb_valid,
  input  logic [ROB_ID_WIDTH-1:0] lsb_dest,
  input  logic [DATA_WIDTH-1:0]   lsb_value,
  output logic                    lsb_ready,
  output logic                    cdb_valid,
  output logic [ROB_ID_WIDTH-1:0] cdb_dest,
  output logic [DATA_WIDTH-1:0]   cdb_value,
  output logic [DATA_WIDTH-1:0]   cdb_next_pc,
  output logic                    cdb_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage (no reset; only entries below count are ever read)
  logic [ROB_ID_WIDTH-1:0] alu_dest_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   alu_value_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   alu_pc_mem_q [DEPTH];
  logic [ROB_ID_WIDTH-1:0] lsb_dest_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   lsb_value_mem_q [DEPTH];

  logic [PW-1:0] alu_wr_ptr_q, alu_wr_ptr_d, alu_rd_ptr_q, alu_rd_ptr_d;
  logic [PW-1:0] lsb_wr_ptr_q, lsb_wr_ptr_d, lsb_rd_ptr_q, lsb_rd_ptr_d;
  logic [CW-1:0] alu_count_q, alu_count_d, lsb_count_q, lsb_count_d;

  // 0 = ALU has priority on a tie, 1 = LSB
  logic prio_q, prio_d;

  logic                    cdb_valid_q, cdb_valid_d;
  logic [ROB_ID_WIDTH-1:0] cdb_dest_q, cdb_dest_d;
  logic [DATA_WIDTH-1:0]   cdb_value_q, cdb_value_d;
  logic [DATA_WIDTH-1:0]   cdb_next_pc_q, cdb_next_pc_d;
  logic                    cdb_src_q, cdb_src_d;

  logic active;
  logic alu_push, lsb_push;
  logic alu_ne, lsb_ne;
  logic grant_alu, grant_lsb;

  // Readiness depends on occupancy only, so a full FIFO stays not-ready even when popping
  assign alu_ready = (alu_count_q != CW'(DEPTH));
  assign lsb_ready = (lsb_count_q != CW'(DEPTH));

  assign active   = rdy && !rst && !flush;
  assign alu_push = active && alu_valid && alu_ready && (alu_dest != '0);
  assign lsb_push = active && lsb_valid && lsb_ready && (lsb_dest != '0);

  // Grants look at occupancy before this edge's pushes, so there is no bypass
  assign alu_ne    = (alu_count_q != '0);
  assign lsb_ne    = (lsb_count_q != '0);
  assign grant_alu = active && alu_ne && (!lsb_ne || !prio_q);
  assign grant_lsb = active && lsb_ne && (!alu_ne || prio_q);

  assign cdb_valid   = cdb_valid_q;
  assign cdb_dest    = cdb_dest_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_next_pc = cdb_next_pc_q;
  assign cdb_src     = cdb_src_q;

  // Next-state for pointers, counts, priority and the broadcast register
  always_comb begin
    alu_wr_ptr_d  = alu_wr_ptr_q;
    alu_rd_ptr_d  = alu_rd_ptr_q;
    lsb_wr_ptr_d  = lsb_wr_ptr_q;
    lsb_rd_ptr_d  = lsb_rd_ptr_q;
    alu_count_d   = alu_count_q;
    lsb_count_d   = lsb_count_q;
    prio_d        = prio_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_dest_d    = cdb_dest_q;
    cdb_value_d   = cdb_value_q;
    cdb_next_pc_d = cdb_next_pc_q;
    cdb_src_d     = cdb_src_q;

    if (rdy && flush) begin
      alu_wr_ptr_d = '0;
      alu_rd_ptr_d = '0;
      lsb_wr_ptr_d = '0;
      lsb_rd_ptr_d = '0;
      alu_count_d  = '0;
      lsb_count_d  = '0;
      prio_d       = 1'b0;
      cdb_valid_d  = 1'b0;
      cdb_src_d    = 1'b0;
    end else if (rdy) begin
      if (alu_push)  alu_wr_ptr_d = alu_wr_ptr_q + PW'(1);
      if (grant_alu) alu_rd_ptr_d = alu_rd_ptr_q + PW'(1);
      if (lsb_push)  lsb_wr_ptr_d = lsb_wr_ptr_q + PW'(1);
      if (grant_lsb) lsb_rd_ptr_d = lsb_rd_ptr_q + PW'(1);

      if (alu_push && !grant_alu)      alu_count_d = alu_count_q + CW'(1);
      else if (!alu_push && grant_alu) alu_count_d = alu_count_q - CW'(1);
      if (lsb_push && !grant_lsb)      lsb_count_d = lsb_count_q + CW'(1);
      else if (!lsb_push && grant_lsb) lsb_count_d = lsb_count_q - CW'(1);

      if (grant_alu) begin
        cdb_valid_d   = 1'b1;
        cdb_dest_d    = alu_dest_mem_q[alu_rd_ptr_q];
        cdb_value_d   = alu_value_mem_q[alu_rd_ptr_q];
        cdb_next_pc_d = alu_pc_mem_q[alu_rd_ptr_q];
        cdb_src_d     = 1'b0;
        prio_d        = 1'b1;
      end else if (grant_lsb) begin
        cdb_valid_d   = 1'b1;
        cdb_dest_d    = lsb_dest_mem_q[lsb_rd_ptr_q];
        cdb_value_d   = lsb_value_mem_q[lsb_rd_ptr_q];
        cdb_next_pc_d = '0;
        cdb_src_d     = 1'b1;
        prio_d        = 1'b0;
      end else begin
        cdb_valid_d   = 1'b0;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wr_ptr_q  <= '0;
      alu_rd_ptr_q  <= '0;
      lsb_wr_ptr_q  <= '0;
      lsb_rd_ptr_q  <= '0;
      alu_count_q   <= '0;
      lsb_count_q   <= '0;
      prio_q        <= 1'b0;
      cdb_valid_q   <= 1'b0;
      cdb_dest_q    <= '0;
      cdb_value_q   <= '0;
      cdb_next_pc_q <= '0;
      cdb_src_q     <= 1'b0;
    end else begin
      alu_wr_ptr_q  <= alu_wr_ptr_d;
      alu_rd_ptr_q  <= alu_rd_ptr_d;
      lsb_wr_ptr_q  <= lsb_wr_ptr_d;
      lsb_rd_ptr_q  <= lsb_rd_ptr_d;
      alu_count_q   <= alu_count_d;
      lsb_count_q   <= lsb_count_d;
      prio_q        <= prio_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_dest_q    <= cdb_dest_d;
      cdb_value_q   <= cdb_value_d;
      cdb_next_pc_q <= cdb_next_pc_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  // FIFO entry writes on accepted pushes
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_dest_mem_q[alu_wr_ptr_q]  <= alu_dest;
      alu_value_mem_q[alu_wr_ptr_q] <= alu_value;
      alu_pc_mem_q[alu_wr_ptr_q]    <= alu_next_pc;
    end
    if (lsb_push) begin
      lsb_dest_mem_q[lsb_wr_ptr_q]  <= lsb_dest;
      lsb_value_mem_q[lsb_wr_ptr_q] <= lsb_value;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (default parameters, DEPTH = 2).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_dest, lsb_dest, cdb_dest;
  logic [31:0] alu_value, alu_next_pc, lsb_value, cdb_value, cdb_next_pc;
  logic        alu_ready, lsb_ready, cdb_valid, cdb_src;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.ROB_ID_WIDTH(4), .DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_value(alu_value),
    .alu_next_pc(alu_next_pc), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_dest(lsb_dest), .lsb_value(lsb_value),
    .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_value(cdb_value),
    .cdb_next_pc(cdb_next_pc), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid = 1'b0; lsb_valid = 1'b0; flush = 1'b0; rdy = 1'b1;
  endtask

  task automatic push_alu(input logic [3:0] d, input logic [31:0] v, input logic [31:0] pc);
    alu_valid = 1'b1; alu_dest = d; alu_value = v; alu_next_pc = pc;
  endtask

  task automatic push_lsb(input logic [3:0] d, input logic [31:0] v);
    lsb_valid = 1'b1; lsb_dest = d; lsb_value = v;
  endtask

  task automatic do_reset;
    idle;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    push_alu(4'hF, 32'hAA, 32'h1234);
    step;
    idle;
    step;
    checks++;
    if ({cdb_valid, cdb_dest, cdb_value} !== {1'b1, 4'hF, 32'hAA}) begin
      failures++;
      $display("FAIL reset_pre got=%h exp=%h", {cdb_valid, cdb_dest, cdb_value}, {1'b1, 4'hF, 32'hAA});
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if ({cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src, alu_ready, lsb_ready} !==
        {1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h",
               {cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src, alu_ready, lsb_ready},
               {1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_single;
    do_reset;
    push_alu(4'd3, 32'h10, 32'h44);
    step;
    idle;
    checks++;
    if ({cdb_valid, alu_ready} !== 2'b01) begin
      failures++;
      $display("FAIL single_latency got=%b exp=01", {cdb_valid, alu_ready});
    end
    step;
    checks++;
    if ({cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src, alu_ready} !==
        {1'b1, 4'd3, 32'h10, 32'h44, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_bcast got=%h exp=%h",
               {cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src, alu_ready},
               {1'b1, 4'd3, 32'h10, 32'h44, 1'b0, 1'b1});
    end
    step;
    checks++;
    if ({cdb_valid, cdb_dest} !== {1'b0, 4'd3}) begin
      failures++;
      $display("FAIL single_pulse got=%h exp=%h", {cdb_valid, cdb_dest}, {1'b0, 4'd3});
    end
  endtask

  task automatic test_round_robin;
    logic [3:0]  ed [4];
    logic [31:0] ev [4];
    logic [31:0] ep [4];
    logic        es [4];
    ed = '{4'd1, 4'd5, 4'd2, 4'd6};
    ev = '{32'h101, 32'h505, 32'h202, 32'h606};
    ep = '{32'h1000, 32'h0, 32'h2000, 32'h0};
    es = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset;
    push_alu(4'd1, 32'h101, 32'h1000);
    push_lsb(4'd5, 32'h505);
    step;
    push_alu(4'd2, 32'h202, 32'h2000);
    push_lsb(4'd6, 32'h606);
    step;
    idle;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src} !== {1'b1, ed[i], ev[i], ep[i], es[i]}) begin
        failures++;
        $display("FAIL rr_order[%0d] got=%h exp=%h", i,
                 {cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src}, {1'b1, ed[i], ev[i], ep[i], es[i]});
      end
      step;
    end
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_end got=%b exp=0", cdb_valid);
    end
  endtask

  task automatic test_alu_full;
    logic [3:0] ed [5];
    logic       es [5];
    ed = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3};
    es = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset;
    push_alu(4'd1, 32'h1, 32'h0);
    push_lsb(4'd9, 32'h9);
    step;
    push_alu(4'd2, 32'h2, 32'h0);
    push_lsb(4'd10, 32'hA);
    step;
    checks++;
    if ({cdb_dest, alu_ready, lsb_ready} !== {4'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL full_e2 got=%h exp=%h", {cdb_dest, alu_ready, lsb_ready}, {4'd1, 1'b1, 1'b0});
    end
    lsb_valid = 1'b0;
    push_alu(4'd3, 32'h3, 32'h0);
    step;
    checks++;
    if ({cdb_dest, alu_ready} !== {4'd9, 1'b0}) begin
      failures++;
      $display("FAIL full_ready_low got=%h exp=%h", {cdb_dest, alu_ready}, {4'd9, 1'b0});
    end
    push_alu(4'd4, 32'h4, 32'h0);
    step;
    idle;
    checks++;
    if ({cdb_dest, alu_ready} !== {4'd2, 1'b1}) begin
      failures++;
      $display("FAIL full_drop got=%h exp=%h", {cdb_dest, alu_ready}, {4'd2, 1'b1});
    end
    for (int i = 3; i < 5; i++) begin
      step;
      checks++;
      if ({cdb_valid, cdb_dest, cdb_src} !== {1'b1, ed[i], es[i]}) begin
        failures++;
        $display("FAIL full_seq[%0d] got=%h exp=%h", i, {cdb_valid, cdb_dest, cdb_src}, {1'b1, ed[i], es[i]});
      end
    end
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if (cdb_valid !== 1'b0) begin
        failures++;
        $display("FAIL full_dropped_tag[%0d] got=%b dest=%0d exp=0", i, cdb_valid, cdb_dest);
      end
    end
  endtask

  task automatic test_flush;
    do_reset;
    push_alu(4'd1, 32'h11, 32'h100);
    push_lsb(4'd5, 32'h55);
    step;
    alu_valid = 1'b0;
    push_lsb(4'd6, 32'h66);
    step;
    lsb_valid = 1'b0;
    checks++;
    if ({cdb_dest, cdb_src, lsb_ready} !== {4'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush_pre got=%h exp=%h", {cdb_dest, cdb_src, lsb_ready}, {4'd1, 1'b0, 1'b0});
    end
    flush = 1'b1;
    push_alu(4'd3, 32'h33, 32'h300);
    step;
    idle;
    checks++;
    if ({cdb_valid, cdb_dest, cdb_value, cdb_next_pc, alu_ready, lsb_ready} !==
        {1'b0, 4'd1, 32'h11, 32'h100, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL flush_state got=%h exp=%h",
               {cdb_valid, cdb_dest, cdb_value, cdb_next_pc, alu_ready, lsb_ready},
               {1'b0, 4'd1, 32'h11, 32'h100, 1'b1, 1'b1});
    end
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if (cdb_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_quiet[%0d] got=%b dest=%0d exp=0", i, cdb_valid, cdb_dest);
      end
    end
    push_alu(4'd7, 32'h77, 32'h700);
    push_lsb(4'd8, 32'h88);
    step;
    idle;
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_bypass got=%b exp=0", cdb_valid);
    end
    step;
    checks++;
    if ({cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src} !== {1'b1, 4'd7, 32'h77, 32'h700, 1'b0}) begin
      failures++;
      $display("FAIL flush_alu_first got=%h exp=%h",
               {cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src}, {1'b1, 4'd7, 32'h77, 32'h700, 1'b0});
    end
    step;
    checks++;
    if ({cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src} !== {1'b1, 4'd8, 32'h88, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL flush_lsb_next got=%h exp=%h",
               {cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src}, {1'b1, 4'd8, 32'h88, 32'h0, 1'b1});
    end
  endtask

  task automatic test_dest_zero_and_rdy;
    do_reset;
    push_alu(4'd0, 32'h99, 32'h0);
    step;
    step;
    idle;
    checks++;
    if ({cdb_valid, alu_ready} !== 2'b01) begin
      failures++;
      $display("FAIL dest0_drop got=%b exp=01", {cdb_valid, alu_ready});
    end
    step;
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("FAIL dest0_quiet got=%b exp=0", cdb_valid);
    end
    push_alu(4'd2, 32'h22, 32'h200);
    step;
    push_alu(4'd4, 32'h44, 32'h400);
    step;
    idle;
    checks++;
    if ({cdb_valid, cdb_dest, cdb_value} !== {1'b1, 4'd2, 32'h22}) begin
      failures++;
      $display("FAIL rdy_pre got=%h exp=%h", {cdb_valid, cdb_dest, cdb_value}, {1'b1, 4'd2, 32'h22});
    end
    rdy   = 1'b0;
    flush = 1'b1;
    push_lsb(4'd9, 32'h99);
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if ({cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src, alu_ready, lsb_ready} !==
          {1'b1, 4'd2, 32'h22, 32'h200, 1'b0, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL rdy_frozen[%0d] got=%h exp=%h", i,
                 {cdb_valid, cdb_dest, cdb_value, cdb_next_pc, cdb_src, alu_ready, lsb_ready},
                 {1'b1, 4'd2, 32'h22, 32'h200, 1'b0, 1'b1, 1'b1});
      end
    end
    idle;
    step;
    checks++;
    if ({cdb_valid, cdb_dest, cdb_value, cdb_next_pc} !== {1'b1, 4'd4, 32'h44, 32'h400}) begin
      failures++;
      $display("FAIL rdy_resume got=%h exp=%h",
               {cdb_valid, cdb_dest, cdb_value, cdb_next_pc}, {1'b1, 4'd4, 32'h44, 32'h400});
    end
    step;
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("FAIL rdy_no_push got=%b dest=%0d exp=0", cdb_valid, cdb_dest);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; alu_dest = '0; alu_value = '0; alu_next_pc = '0;
    lsb_valid = 1'b0; lsb_dest = '0; lsb_value = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_alu_full;
    test_flush;
    test_dest_zero_and_rdy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
